// File: rtl/key_schedule_engine_pkg.sv
// key_sched_pkg: definitions shared by the key schedule engine and its mixer.
//   state_e   : engine FSM states (IDLE, EMIT, DONE)
//   mix_sel_e : which transform of the stage word is used for a chunk
//   MIX_A5    : byte replicated across the word for the last mix term
//   mix_sel() : maps chunk index (mod 8) to a mix selection
package key_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    MIX_ZERO  = 3'd0,
    MIX_STAGE = 3'd1,
    MIX_SWAP  = 3'd2,
    MIX_INV   = 3'd3,
    MIX_ROTQ  = 3'd4,
    MIX_SHL1  = 3'd5,
    MIX_SHR3  = 3'd6,
    MIX_XA5   = 3'd7
  } mix_sel_e;

  localparam logic [7:0] MIX_A5 = 8'hA5;

  // Only the low three index bits matter: the mix pattern repeats every 8 chunks.
  function automatic mix_sel_e mix_sel(input logic [2:0] j);
    return mix_sel_e'(j);
  endfunction

endpackage

// File: rtl/key_schedule_engine_if.sv
// key_schedule_engine_if: request + chunk stream + status bundle.
//   master : drives start/key/stage/mode and chunk_ready (the requester)
//   slave  : drives chunk_valid/chunk/chunk_idx/busy/done/expanded_key (the engine)
// Handshake: a chunk transfers on a rising clk edge where chunk_valid and
// chunk_ready are both 1. Once chunk_valid is raised, chunk and chunk_idx stay
// constant until that transfer; chunk_valid never depends on chunk_ready.
// start is level-sampled only while the engine is idle.
interface key_schedule_engine_if #(
  parameter int KEY_W      = 32,
  parameter int NUM_CHUNKS = 8
);
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  logic                        start;
  logic [KEY_W-1:0]            key;
  logic [KEY_W-1:0]            stage;
  logic                        mode;
  logic                        chunk_valid;
  logic                        chunk_ready;
  logic [KEY_W-1:0]            chunk;
  logic [IDX_W-1:0]            chunk_idx;
  logic                        busy;
  logic                        done;
  logic [KEY_W*NUM_CHUNKS-1:0] expanded_key;

  modport master (
    output start, key, stage, mode, chunk_ready,
    input  chunk_valid, chunk, chunk_idx, busy, done, expanded_key
  );

  modport slave (
    input  start, key, stage, mode, chunk_ready,
    output chunk_valid, chunk, chunk_idx, busy, done, expanded_key
  );
endinterface

// File: rtl/key_schedule_engine_chunk_mix.sv
// key_chunk_mix: combinational chunk generator.
//   key_i, stage_i : schedule operands
//   idx_i          : chunk index i
//   prev_i         : chunk i-1 (only used in chained mode, ignored for i=0)
//   mode_i         : 0 legacy, 1 chained
//   chunk_o        : key ^ m(i mod 8) ^ (i>>3) [^ rotl(prev,1) when chained]
module key_chunk_mix
  import key_sched_pkg::*;
#(
  parameter int KEY_W = 32,
  parameter int IDX_W = 3
) (
  input  logic [KEY_W-1:0] key_i,
  input  logic [KEY_W-1:0] stage_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [KEY_W-1:0] prev_i,
  input  logic             mode_i,
  output logic [KEY_W-1:0] chunk_o
);
  localparam int H = KEY_W / 2;
  localparam int Q = KEY_W / 4;

  logic [5:0]       idx6;
  logic [KEY_W-1:0] a5_pat;
  logic [KEY_W-1:0] mix;
  logic [KEY_W-1:0] legacy;

  // 0xA5 repeated across the word, truncated if KEY_W is not a byte multiple.
  for (genvar b = 0; b < KEY_W; b++) begin : g_a5
    assign a5_pat[b] = MIX_A5[b % 8];
  end

  always_comb begin
    idx6 = 6'(idx_i);
    case (mix_sel(idx6[2:0]))
      MIX_ZERO:  mix = '0;
      MIX_STAGE: mix = stage_i;
      MIX_SWAP:  mix = {stage_i[H-1:0], stage_i[KEY_W-1:H]};
      MIX_INV:   mix = ~stage_i;
      MIX_ROTQ:  mix = {stage_i[KEY_W-Q-1:0], stage_i[KEY_W-1:KEY_W-Q]};
      MIX_SHL1:  mix = stage_i << 1;
      MIX_SHR3:  mix = stage_i >> 3;
      MIX_XA5:   mix = stage_i ^ a5_pat;
      default:   mix = '0;
    endcase
    legacy  = key_i ^ mix ^ KEY_W'(idx6[5:3]);
    chunk_o = (mode_i && (idx6 != 6'd0))
            ? legacy ^ {prev_i[KEY_W-2:0], prev_i[KEY_W-1]}
            : legacy;
  end
endmodule

// File: rtl/key_schedule_engine.sv
// key_schedule_engine: expands (key, stage, mode) into NUM_CHUNKS chunks,
// streamed over a valid/ready port and accumulated into expanded_key
// (chunk 0 in the MSBs).
//   clk, rst_n : clock, asynchronous active-low reset (release synchronised)
//   bus        : key_schedule_engine_if.slave (request, chunk stream, status)
//   state_o    : current FSM state, for observation
module key_schedule_engine
  import key_sched_pkg::*;
#(
  parameter int KEY_W      = 32,
  parameter int NUM_CHUNKS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  key_schedule_engine_if.slave  bus,
  output state_e                state_o
);
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  // Assert asynchronously, release after two clk edges.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  state_e                      state_q, state_d;
  logic [KEY_W-1:0]            key_q, key_d;
  logic [KEY_W-1:0]            stage_q, stage_d;
  logic                        mode_q, mode_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [KEY_W-1:0]            chunk_q, chunk_d;
  logic [KEY_W*NUM_CHUNKS-1:0] ek_q, ek_d;

  // One mixer, shared: in IDLE it precomputes chunk 0 from the live request,
  // in EMIT it computes the chunk after the one currently presented.
  logic [KEY_W-1:0] mix_key, mix_stage, mix_prev, mix_chunk;
  logic [IDX_W-1:0] mix_idx;
  logic             mix_mode;
  logic             xfer;

  key_chunk_mix #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_mix (
    .key_i   (mix_key),
    .stage_i (mix_stage),
    .idx_i   (mix_idx),
    .prev_i  (mix_prev),
    .mode_i  (mix_mode),
    .chunk_o (mix_chunk)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      stage_q <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      chunk_q <= '0;
      ek_q    <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      stage_q <= stage_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      chunk_q <= chunk_d;
      ek_q    <= ek_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    stage_d   = stage_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    chunk_d   = chunk_q;
    ek_d      = ek_q;
    mix_key   = key_q;
    mix_stage = stage_q;
    mix_mode  = mode_q;
    mix_idx   = idx_q + 1'b1;
    mix_prev  = chunk_q;
    xfer      = (state_q == EMIT) && bus.chunk_ready;

    case (state_q)
      IDLE: begin
        mix_key   = bus.key;
        mix_stage = bus.stage;
        mix_mode  = bus.mode;
        mix_idx   = '0;
        mix_prev  = '0;
        if (bus.start) begin
          key_d   = bus.key;
          stage_d = bus.stage;
          mode_d  = bus.mode;
          idx_d   = '0;
          chunk_d = mix_chunk;
          ek_d    = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (xfer) begin
          ek_d[(NUM_CHUNKS - 1 - int'(idx_q)) * KEY_W +: KEY_W] = chunk_q;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            chunk_d = mix_chunk;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.chunk_valid  = (state_q == EMIT);
  assign bus.busy         = (state_q == EMIT);
  assign bus.done         = (state_q == DONE);
  assign bus.chunk        = chunk_q;
  assign bus.chunk_idx    = idx_q;
  assign bus.expanded_key = ek_q;
  assign state_o          = state_q;
endmodule
